// File: rtl/s3g_pkg.sv
// Shared S3G definitions: framing constants, receiver states and the
// team CRC8 step (poly 0x07, MSB first) used by both rx and tx paths.
package s3g_pkg;

    localparam logic [7:0] S3G_START   = 8'hD5;
    localparam int         S3G_MAX_LEN = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CRC
    } s3g_state_e;

    function automatic logic [7:0] nextCRC8_D8(
        input logic [7:0] data,
        input logic [7:0] crc
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_rx_if.sv
// Byte stream in from the UART receiver, framed packet out to the
// command decoder. The source side is master, the framer is slave.
interface s3g_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       packet_valid;
    logic       crc_error;
    logic       len_error;
    logic       timeout_error;
    logic       busy;
    logic [7:0] payload_len;
    logic [7:0] buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7;
    logic [7:0] buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15;

    modport master (
        output rx_data, rx_valid,
        input  packet_valid, crc_error, len_error, timeout_error,
        input  busy, payload_len,
        input  buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7,
        input  buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15
    );

    modport slave (
        input  rx_data, rx_valid,
        output packet_valid, crc_error, len_error, timeout_error,
        output busy, payload_len,
        output buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7,
        output buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15
    );

endinterface

// File: rtl/s3g_crc8.sv
// Registered CRC8 accumulator: clear has priority over en.
module s3g_crc8
    import s3g_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = nextCRC8_D8(data, crc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= 8'h00;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/s3g_rx.sv
// S3G receive framer: hunts 0xD5, captures length, payload and CRC8.
// Define S3G_RX_TIMEOUT_EN to build the inter-byte timeout counter.
module s3g_rx
    import s3g_pkg::*;
#(
    parameter int MAX_LEN = S3G_MAX_LEN
`ifdef S3G_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input logic       clk,
    input logic       rst,
    s3g_rx_if.slave   bus
);

    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    s3g_state_e state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] wbuf_q [S3G_MAX_LEN];
    logic [7:0] wbuf_d [S3G_MAX_LEN];
    logic [7:0] obuf_q [S3G_MAX_LEN];
    logic [7:0] obuf_d [S3G_MAX_LEN];
    logic [7:0] plen_q, plen_d;
    logic       pv_q, pv_d;
    logic       ce_q, ce_d;
    logic       le_q, le_d;
    logic       te_q, te_d;
    logic [7:0] crc_val;
    logic       crc_clr;
    logic       crc_en;
    logic       expire;
    logic       busy;

    assign busy = (state_q != S_IDLE);

`ifdef S3G_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;

    // An arriving byte always beats expiry on the same cycle.
    always_comb begin
        tmo_d  = '0;
        expire = 1'b0;
        if (busy && !bus.rx_valid) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) expire = 1'b1;
            else tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (expire) begin
            state_d = S_IDLE;
        end else if (bus.rx_valid) begin
            unique case (state_q)
                S_IDLE: if (bus.rx_data == S3G_START) state_d = S_LEN;
                S_LEN: begin
                    if (bus.rx_data > MAX_B)       state_d = S_IDLE;
                    else if (bus.rx_data == 8'h00) state_d = S_CRC;
                    else                           state_d = S_DATA;
                end
                S_DATA: begin
                    if ({4'd0, cnt_q} == len_q - 8'd1) state_d = S_CRC;
                end
                S_CRC:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        len_d   = len_q;
        cnt_d   = cnt_q;
        wbuf_d  = wbuf_q;
        obuf_d  = obuf_q;
        plen_d  = plen_q;
        pv_d    = 1'b0;
        ce_d    = 1'b0;
        le_d    = 1'b0;
        te_d    = expire;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        if (bus.rx_valid) begin
            unique case (state_q)
                S_LEN: begin
                    if (bus.rx_data > MAX_B) begin
                        le_d = 1'b1;
                    end else begin
                        len_d   = bus.rx_data;
                        cnt_d   = 4'd0;
                        crc_clr = 1'b1;
                    end
                end
                S_DATA: begin
                    wbuf_d[cnt_q] = bus.rx_data;
                    crc_en        = 1'b1;
                    cnt_d         = cnt_q + 4'd1;
                end
                S_CRC: begin
                    if (bus.rx_data == crc_val) begin
                        pv_d   = 1'b1;
                        plen_d = len_q;
                        // Stale bytes from a longer earlier packet are masked.
                        for (int i = 0; i < S3G_MAX_LEN; i++) begin
                            obuf_d[i] = (8'(i) < len_q) ? wbuf_q[i] : 8'h00;
                        end
                    end else begin
                        ce_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= 8'h00;
            cnt_q  <= 4'd0;
            plen_q <= 8'h00;
            pv_q   <= 1'b0;
            ce_q   <= 1'b0;
            le_q   <= 1'b0;
            te_q   <= 1'b0;
            for (int i = 0; i < S3G_MAX_LEN; i++) begin
                wbuf_q[i] <= 8'h00;
                obuf_q[i] <= 8'h00;
            end
        end else begin
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            plen_q <= plen_d;
            pv_q   <= pv_d;
            ce_q   <= ce_d;
            le_q   <= le_d;
            te_q   <= te_d;
            wbuf_q <= wbuf_d;
            obuf_q <= obuf_d;
        end
    end

    s3g_crc8 u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (crc_clr),
        .en    (crc_en),
        .data  (bus.rx_data),
        .crc   (crc_val)
    );

    assign bus.packet_valid  = pv_q;
    assign bus.crc_error     = ce_q;
    assign bus.len_error     = le_q;
    assign bus.timeout_error = te_q;
    assign bus.busy          = busy;
    assign bus.payload_len   = plen_q;
    assign bus.buf0  = obuf_q[0];
    assign bus.buf1  = obuf_q[1];
    assign bus.buf2  = obuf_q[2];
    assign bus.buf3  = obuf_q[3];
    assign bus.buf4  = obuf_q[4];
    assign bus.buf5  = obuf_q[5];
    assign bus.buf6  = obuf_q[6];
    assign bus.buf7  = obuf_q[7];
    assign bus.buf8  = obuf_q[8];
    assign bus.buf9  = obuf_q[9];
    assign bus.buf10 = obuf_q[10];
    assign bus.buf11 = obuf_q[11];
    assign bus.buf12 = obuf_q[12];
    assign bus.buf13 = obuf_q[13];
    assign bus.buf14 = obuf_q[14];
    assign bus.buf15 = obuf_q[15];

endmodule
